// File: rtl/lfsr_roll_hist.sv
// Dice roller: a seeded LFSR rolls for a fixed run and the display slows down in stages.
// Each committed result goes into a small circular history that can be stepped back through.
module lfsr_roll_hist #(
  parameter int unsigned       OUT_W      = 4,
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'h002D,
  parameter int unsigned       RUN_W      = 15,
  parameter int unsigned       STAGE_BITS = 2,
  parameter int unsigned       BASE_SHIFT = 9,
  parameter int unsigned       HIST_DEPTH = 4,
  localparam int unsigned      HW         = $clog2(HIST_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop_n,
  input  logic             i_recall,
  output logic [OUT_W-1:0] o_rand,
  output logic             o_busy,
  output logic             o_valid,
  output logic [HW-1:0]    o_hist_idx
);

  localparam int unsigned CW = HW + 1;

  if (BASE_SHIFT + (1 << STAGE_BITS) - 1 > RUN_W - STAGE_BITS) begin : g_bad_timing
    $error("lfsr_roll_hist: slowest update period does not fit in one stage");
  end
  if (OUT_W > LFSR_W) begin : g_bad_width
    $error("lfsr_roll_hist: OUT_W must not exceed LFSR_W");
  end

  typedef enum logic {IDLE, ROLL} state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] seed_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [OUT_W-1:0]  hist [HIST_DEPTH];
  logic [HW-1:0]     wp;
  logic [CW-1:0]     count;

  logic [STAGE_BITS-1:0] stage_c;
  logic [RUN_W-1:0]      shamt_c;
  logic [RUN_W-1:0]      upd_mask_c;
  logic                  upd_c;
  logic                  terminal_c;
  logic [LFSR_W-1:0]     seeded_c;
  logic                  fb_c;
  logic [OUT_W-1:0]      commit_val_c;
  logic [CW-1:0]         idx_inc_c;
  logic [HW-1:0]         idx_next_c;
  logic [CW-1:0]         rd_sum_c;
  logic [CW-1:0]         rd_idx_c;
  logic [HW-1:0]         wp_next_c;

  // Update period doubles with each deceleration stage
  always_comb begin
    stage_c      = run_cnt[RUN_W-1 -: STAGE_BITS];
    shamt_c      = RUN_W'(BASE_SHIFT) + RUN_W'(stage_c);
    upd_mask_c   = (RUN_W'(1) << shamt_c) - RUN_W'(1);
    upd_c        = &(run_cnt | ~upd_mask_c);
    terminal_c   = &run_cnt;
    seeded_c     = lfsr ^ seed_cnt;
    fb_c         = ^(lfsr & TAPS);
    commit_val_c = (terminal_c || upd_c) ? lfsr[OUT_W-1:0] : o_rand;
  end

  // Recall steps one entry older and wraps back to the newest once every entry has been shown
  always_comb begin
    idx_inc_c  = {1'b0, o_hist_idx} + CW'(1);
    idx_next_c = (idx_inc_c == count) ? '0 : idx_inc_c[HW-1:0];
    rd_sum_c   = {1'b0, wp} + CW'(HIST_DEPTH - 1) - {1'b0, idx_next_c};
    rd_idx_c   = (rd_sum_c >= CW'(HIST_DEPTH)) ? rd_sum_c - CW'(HIST_DEPTH) : rd_sum_c;
    wp_next_c  = (wp == HW'(HIST_DEPTH - 1)) ? '0 : wp + HW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      lfsr       <= '0;
      seed_cnt   <= '0;
      run_cnt    <= '0;
      wp         <= '0;
      count      <= '0;
      o_rand     <= '0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_hist_idx <= '0;
      for (int i = 0; i < int'(HIST_DEPTH); i++) hist[i] <= '0;
    end else begin
      seed_cnt <= seed_cnt + LFSR_W'(1);
      o_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            lfsr       <= (seeded_c == '0) ? LFSR_W'(1) : seeded_c;
            run_cnt    <= '0;
            o_hist_idx <= '0;
            o_busy     <= 1'b1;
            state      <= ROLL;
          end else if (i_recall && (count >= CW'(2))) begin
            o_hist_idx <= idx_next_c;
            o_rand     <= hist[rd_idx_c[HW-1:0]];
          end
        end
        ROLL: begin
          lfsr    <= {fb_c, lfsr[LFSR_W-1:1]};
          run_cnt <= run_cnt + RUN_W'(1);
          if (terminal_c || !i_stop_n) begin
            o_rand   <= commit_val_c;
            hist[wp] <= commit_val_c;
            wp       <= wp_next_c;
            if (count != CW'(HIST_DEPTH)) count <= count + CW'(1);
            o_valid  <= 1'b1;
            o_busy   <= 1'b0;
            state    <= IDLE;
          end else if (upd_c) begin
            o_rand <= lfsr[OUT_W-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_roll_hist.sv
// Bench for lfsr_roll_hist with a shortened run (256 cycles, 64-cycle stages) and
// a cycle-by-cycle reference model built from roll index, update period and a result queue.
module tb_lfsr_roll_hist;

  localparam int unsigned OUT_W      = 4;
  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned RUN_W      = 8;
  localparam int unsigned STAGE_BITS = 2;
  localparam int unsigned BASE_SHIFT = 3;
  localparam int unsigned HIST_DEPTH = 4;
  localparam int          ROLL_LEN   = 1 << RUN_W;
  localparam int          STAGE_LEN  = ROLL_LEN >> STAGE_BITS;
  localparam int          TAPS_I     = 'h002D;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop_n = 1'b1;
  logic             recall = 1'b0;
  logic [OUT_W-1:0] rnd;
  logic             busy;
  logic             valid;
  logic [1:0]       hist_idx;

  int total = 0;
  int bad = 0;
  int edges = 0;

  int m_lfsr = 0;
  int m_rand = 0;
  int m_idx  = 0;
  int q[$];

  lfsr_roll_hist #(
    .OUT_W(OUT_W), .LFSR_W(LFSR_W), .TAPS(16'h002D), .RUN_W(RUN_W),
    .STAGE_BITS(STAGE_BITS), .BASE_SHIFT(BASE_SHIFT), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop_n(stop_n),
    .i_recall(recall), .o_rand(rnd), .o_busy(busy), .o_valid(valid),
    .o_hist_idx(hist_idx)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release, i.e. the seed counter value
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_next(input int x);
    int p = 0;
    for (int i = 0; i < int'(LFSR_W); i++)
      if (((TAPS_I >> i) & 1) == 1 && ((x >> i) & 1) == 1) p ^= 1;
    return (p << (LFSR_W - 1)) | (x >> 1);
  endfunction

  function automatic bit is_upd(input int k);
    int period = 1 << (BASE_SHIFT + k / STAGE_LEN);
    return ((k + 1) % period) == 0;
  endfunction

  task automatic check_all(input string tag, input bit exp_busy, input bit exp_valid);
    chk({tag, ".rand"},  32'(rnd),      32'(m_rand));
    chk({tag, ".busy"},  32'(busy),     32'(exp_busy));
    chk({tag, ".valid"}, 32'(valid),    32'(exp_valid));
    chk({tag, ".idx"},   32'(hist_idx), 32'(m_idx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      stop_n = 1'($urandom);
      @(posedge clk); @(negedge clk);
      check_all("idle", 1'b0, 1'b0);
    end
    stop_n = 1'b1;
  endtask

  task automatic do_recall();
    recall = 1'b1;
    @(posedge clk); @(negedge clk);
    recall = 1'b0;
    if (q.size() >= 2) begin
      m_idx  = (m_idx + 1 == q.size()) ? 0 : m_idx + 1;
      m_rand = q[q.size() - 1 - m_idx];
    end
    check_all("recall", 1'b0, 1'b0);
  endtask

  // One roll from a negedge in IDLE; stop_at/restart_at/abort_at < 0 disable those events
  task automatic run_roll(input int stop_at, input bit recall_too, input int restart_at,
                          input int abort_at);
    int  cur;
    bit  upd;
    m_lfsr = (m_lfsr ^ (edges & 'hFFFF));
    if (m_lfsr == 0) m_lfsr = 1;
    start  = 1'b1;
    recall = recall_too;
    @(posedge clk); @(negedge clk);
    start  = 1'b0;
    recall = 1'b0;
    m_idx  = 0;
    check_all("start", 1'b1, 1'b0);
    for (int k = 0; k < ROLL_LEN; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        m_rand = 0; m_idx = 0; m_lfsr = 0; q.delete();
        check_all("abort", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      stop_n = (k == stop_at) ? 1'b0 : 1'b1;
      start  = (k == restart_at);
      recall = ($urandom_range(0, 7) == 0);
      @(posedge clk); @(negedge clk);
      stop_n = 1'b1; start = 1'b0; recall = 1'b0;
      cur = m_lfsr & ((1 << OUT_W) - 1);
      upd = is_upd(k);
      m_lfsr = lfsr_next(m_lfsr);
      if (k == ROLL_LEN - 1 || k == stop_at) begin
        if (upd) m_rand = cur;
        q.push_back(m_rand);
        if (q.size() > int'(HIST_DEPTH)) void'(q.pop_front());
        check_all("commit", 1'b0, 1'b1);
        @(posedge clk); @(negedge clk);
        check_all("after", 1'b0, 1'b0);
        return;
      end
      if (upd) m_rand = cur;
      chk("roll.rand",  32'(rnd),   32'(m_rand));
      chk("roll.busy",  32'(busy),  32'(1));
      chk("roll.valid", 32'(valid), 32'(0));
    end
  endtask

  initial begin
    // Reset held for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("rst.valid", 32'(valid), 32'(0));
    end
    check_all("reset", 1'b0, 1'b0);

    // Start on the first edge after release: seed 0 with lfsr 0 loads 1
    rst_n = 1'b1;
    run_roll(-1, 1'b0, -1, -1);
    idle(3);

    // Early stops: mid-stage, first cycle, on an update cycle, random point
    run_roll(20, 1'b0, -1, -1);
    idle($urandom_range(1, 5));
    run_roll(0, 1'b0, -1, -1);
    idle($urandom_range(1, 5));
    run_roll(7, 1'b0, -1, -1);
    idle($urandom_range(1, 5));
    run_roll($urandom_range(1, ROLL_LEN - 2), 1'b0, -1, -1);
    idle(2);

    // Five full rolls then walk the history
    for (int r = 0; r < 5; r++) begin
      run_roll(-1, 1'b0, -1, -1);
      idle($urandom_range(1, 6));
    end
    for (int i = 0; i < 5; i++) do_recall();

    // Start beats recall; start during roll does not restart
    do_recall();
    run_roll(-1, 1'b1, 50, -1);
    idle(2);
    do_recall();

    // Async reset mid-roll, then recall does nothing
    run_roll(-1, 1'b0, -1, 100);
    check_all("post_rst", 1'b0, 1'b0);
    do_recall();
    run_roll(-1, 1'b0, -1, -1);
    do_recall();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
